// File: rtl/key_expansion_seq_if.sv
// Key-schedule port bundle: start/key request, round-key read port and status flags.
interface key_expansion_seq_if;
  logic         start;
  logic [127:0] cipher_key;
  logic [3:0]   round_sel;
  logic [127:0] round_key;
  logic         busy;
  logic         keys_valid;
  logic         done_pulse;

  modport master (
    output start, cipher_key, round_sel,
    input  round_key, busy, keys_valid, done_pulse
  );

  modport slave (
    input  start, cipher_key, round_sel,
    output round_key, busy, keys_valid, done_pulse
  );
endinterface

// File: rtl/key_expansion_seq.sv
// Sequential AES-128 key schedule: one round key per clock into an 11-entry store,
// combinational read by round index; start is ignored while busy.
module key_expansion_seq #(
  parameter int NR = 10
) (
  input  logic clk,
  input  logic n_rst,
  key_expansion_seq_if.slave kx
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       state_q;
  logic [3:0]   rnd_cnt_q;
  logic [7:0]   rcon_q;
  logic         busy_q;
  logic         valid_q;
  logic         done_q;
  logic [127:0] key_mem_q [NR+1];

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] pos;
    pos = {x, 3'b000};
    return SBOX_TBL[11'd2047 - pos -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // t = SubWord(RotWord(w3)) ^ {rcon,0}; each later word chains off the previous new word.
  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      rnd_cnt_q <= 4'd0;
      rcon_q    <= 8'h01;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i <= NR; i++) key_mem_q[i] <= 128'h0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (kx.start) begin
            key_mem_q[0] <= kx.cipher_key;
            rnd_cnt_q    <= 4'd1;
            rcon_q       <= 8'h01;
            state_q      <= EXPAND;
            busy_q       <= 1'b1;
            valid_q      <= 1'b0;
          end
        end
        EXPAND: begin
          key_mem_q[rnd_cnt_q] <= next_rk(key_mem_q[rnd_cnt_q - 4'd1], rcon_q);
          rcon_q               <= xtime(rcon_q);
          if (rnd_cnt_q == 4'(NR)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            rnd_cnt_q <= rnd_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    kx.round_key = 128'h0;
    if (kx.round_sel <= 4'(NR)) kx.round_key = key_mem_q[kx.round_sel];
  end

  assign kx.busy       = busy_q;
  assign kx.keys_valid = valid_q;
  assign kx.done_pulse = done_q;

endmodule
